data_memory_interface: RTL

- Sits directly downstream of the single-cycle datapath. Consumes the ALU address (aluout), the store data (writedata) and the control unit's memread/memwrite strobes, and returns readdata to the result mux.
- Turns each single-cycle load/store into a req/ack transaction on a variable-latency data-memory bus.
- Asserts stall to freeze the PC and register-file write until the access completes.
- Also flags misaligned word accesses and bus timeouts.

---
 rtl/data_memory_interface_pkg.sv | 20 ++
 rtl/data_memory_interface_if.sv | 34 +++
 rtl/data_memory_interface_timeout_counter.sv | 37 +++
 rtl/data_memory_interface.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/data_memory_interface_pkg.sv
// Shared types and defaults for the data-memory bus adapter that sits behind
// the single-cycle datapath.
package data_memory_interface_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int          DEFAULT_ADDR_WIDTH  = 16;
  localparam int          DEFAULT_TIMEOUT     = 255;
  localparam logic [31:0] DEFAULT_ERR_PATTERN = 32'hDEADBEEF;
  localparam int          CNT_WIDTH           = 16;

  function automatic logic word_aligned(input logic [1:0] byte_offset);
    return (byte_offset == 2'b00);
  endfunction

endpackage

// File: rtl/data_memory_interface_if.sv
// Variable-latency data-memory bus: registered request side from the adapter,
// one-cycle ack with read data from memory.
interface data_memory_interface_if
  import data_memory_interface_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;
  logic                  bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );

endinterface

// File: rtl/data_memory_interface_timeout_counter.sv
// Saturating wait counter for the REQ phase; terminal flags the cycle in which
// the count reaches TIMEOUT.
module data_memory_interface_timeout_counter
  import data_memory_interface_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] LAST  = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] count_r;

  // Count REQ cycles, holding at LIMIT so a long wait never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else if (enable && (count_r < LIMIT)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // This cycle's increment is the one that reaches TIMEOUT.
  assign terminal = enable & (count_r >= LAST);

endmodule

// File: rtl/data_memory_interface.sv
// Turns single-cycle load/store strobes into a req/ack bus transaction and
// stalls the core until it completes, times out, or is rejected as misaligned.
module data_memory_interface
  import data_memory_interface_pkg::*;
#(
  parameter int          ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int          TIMEOUT     = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_PATTERN = DEFAULT_ERR_PATTERN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memread,
  input  logic                    memwrite,
  input  logic [31:0]             addr,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic                    stall,
  output logic                    misaligned,
  output logic                    bus_error,
  data_memory_interface_if.master bus
);

  state_t                state_r;
  state_t                state_s;
  logic                  bus_req_r;
  logic                  bus_req_s;
  logic                  bus_we_r;
  logic                  bus_we_s;
  logic [ADDR_WIDTH-1:0] bus_addr_r;
  logic [ADDR_WIDTH-1:0] bus_addr_s;
  logic [31:0]           bus_wdata_r;
  logic [31:0]           bus_wdata_s;
  logic [31:0]           capture_r;
  logic [31:0]           capture_s;
  logic                  bus_error_r;
  logic                  bus_error_s;
  logic                  cnt_clear_s;
  logic                  cnt_enable_s;
  logic                  cnt_terminal_s;
  logic                  access_s;
  logic                  aligned_s;
  logic                  stall_s;
  logic                  misaligned_s;
  logic [31:0]           readdata_s;
  logic                  unused_addr_s;

  assign access_s      = memread | memwrite;
  assign aligned_s     = word_aligned(addr[1:0]);
  assign unused_addr_s = ^addr[31:ADDR_WIDTH+2];

  data_memory_interface_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear_s),
    .enable   (cnt_enable_s),
    .terminal (cnt_terminal_s)
  );

  // Next-state, next bus request and core-facing handshake.
  always_comb begin
    state_s      = state_r;
    bus_req_s    = bus_req_r;
    bus_we_s     = bus_we_r;
    bus_addr_s   = bus_addr_r;
    bus_wdata_s  = bus_wdata_r;
    capture_s    = capture_r;
    bus_error_s  = bus_error_r;
    cnt_clear_s  = 1'b0;
    cnt_enable_s = 1'b0;
    stall_s      = 1'b0;
    misaligned_s = 1'b0;
    readdata_s   = 32'h0000_0000;

    case (state_r)
      ST_IDLE: begin
        if (access_s && aligned_s) begin
          stall_s     = 1'b1;
          bus_req_s   = 1'b1;
          bus_we_s    = memwrite;
          bus_addr_s  = addr[ADDR_WIDTH+1:2];
          bus_wdata_s = writedata;
          capture_s   = 32'h0000_0000;
          cnt_clear_s = 1'b1;
          state_s     = ST_REQ;
        end else if (access_s) begin
          misaligned_s = 1'b1;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_REQ: begin
        stall_s      = 1'b1;
        cnt_enable_s = 1'b1;
        // An ack in the terminal-count cycle still counts as a clean completion.
        if (bus.bus_ack) begin
          bus_req_s = 1'b0;
          bus_we_s  = 1'b0;
          capture_s = bus_we_r ? 32'h0000_0000 : bus.bus_rdata;
          state_s   = ST_DONE;
        end else if (cnt_terminal_s) begin
          bus_req_s   = 1'b0;
          bus_we_s    = 1'b0;
          bus_error_s = 1'b1;
          capture_s   = bus_we_r ? 32'h0000_0000 : ERR_PATTERN;
          state_s     = ST_DONE;
        end else begin
          state_s = ST_REQ;
        end
      end

      ST_DONE: begin
        readdata_s = capture_r;
        state_s    = ST_IDLE;
      end

      default: begin
        bus_req_s = 1'b0;
        bus_we_s  = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State, bus request, capture and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= {ADDR_WIDTH{1'b0}};
      bus_wdata_r <= 32'h0000_0000;
      capture_r   <= 32'h0000_0000;
      bus_error_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      bus_req_r   <= bus_req_s;
      bus_we_r    <= bus_we_s;
      bus_addr_r  <= bus_addr_s;
      bus_wdata_r <= bus_wdata_s;
      capture_r   <= capture_s;
      bus_error_r <= bus_error_s;
    end
  end

  // The core may still present an access while reset is held; keep it unstalled.
  assign stall         = stall_s & reset;
  assign misaligned    = misaligned_s & reset;
  assign readdata      = readdata_s;
  assign bus_error     = bus_error_r;
  assign bus.bus_req   = bus_req_r;
  assign bus.bus_we    = bus_we_r;
  assign bus.bus_addr  = bus_addr_r;
  assign bus.bus_wdata = bus_wdata_r;

endmodule
